lsu_port_arbiter: RTL

//  Shares the single data-side LSU port between two requesters: port 0 (exec_mem, data loads/stores/AMOs)
//  and port 1 (secondary client, e.g. page-table walker or debug access). Each upstream port speaks the

---
 rtl/lsu_port_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_port_arbiter.sv
// rtl/lsu_port_arbiter.sv - two-port arbiter in front of the data-side LSU
module lsu_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int ADDR_W       = 58,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  // port 0: exec_mem
  input  logic                p0_prev_stalled,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic                p0_do_load,
  input  logic                p0_do_store,
  input  logic [XLEN-1:0]     p0_store_data,
  input  logic [XLEN/8-1:0]   p0_store_mask,
  input  logic                p0_lock,
  output logic                p0_stall_next,
  output logic                p0_access_fault,
  output logic [XLEN-1:0]     p0_load_data,
  // port 1: secondary client
  input  logic                p1_prev_stalled,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic                p1_do_load,
  input  logic                p1_do_store,
  input  logic [XLEN-1:0]     p1_store_data,
  input  logic [XLEN/8-1:0]   p1_store_mask,
  output logic                p1_stall_next,
  output logic                p1_access_fault,
  output logic [XLEN-1:0]     p1_load_data,
  // downstream LSU
  output logic                lsu_prev_stalled,
  output logic [ADDR_W-1:0]   lsu_addr,
  output logic                lsu_do_load,
  output logic                lsu_do_store,
  output logic [XLEN-1:0]     lsu_store_data,
  output logic [XLEN/8-1:0]   lsu_store_mask,
  input  logic                lsu_stall_next,
  input  logic                lsu_access_fault,
  input  logic [XLEN-1:0]     lsu_load_data
);

  localparam int MASK_W = XLEN / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_LOCK0} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              ld;
    logic              st;
    logic [XLEN-1:0]   data;
    logic [MASK_W-1:0] mask;
  } req_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [1:0]       pend_v_q, pend_v_d;
  req_t             pend0_q, pend0_d;
  req_t             pend1_q, pend1_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  req_t live0, live1, req0, req1, issue_req;
  logic resp, busy0, busy1, acc0, acc1, cand0, cand1;
  logic locked, elig1, window, grant0, grant1, issue;

  assign live0 = {p0_addr, p0_do_load, p0_do_store, p0_store_data, p0_store_mask};
  assign live1 = {p1_addr, p1_do_load, p1_do_store, p1_store_data, p1_store_mask};

  // Response decode, port occupancy, candidates and the lock window.
  always_comb begin
    resp   = (state_q == ST_BUSY) && !lsu_stall_next;
    // A port is busy while it holds a buffered request or an unanswered in-flight one;
    // the owner becomes free in its response cycle so it can issue back-to-back.
    busy0  = pend_v_q[0] || ((state_q == ST_BUSY) && !owner_q && !resp);
    busy1  = pend_v_q[1] || ((state_q == ST_BUSY) &&  owner_q && !resp);
    acc0   = !p0_prev_stalled && !busy0;
    acc1   = !p1_prev_stalled && !busy1;
    cand0  = pend_v_q[0] || acc0;
    cand1  = pend_v_q[1] || acc1;
    req0   = pend_v_q[0] ? pend0_q : live0;
    req1   = pend_v_q[1] ? pend1_q : live1;
    // The lock already applies in the response cycle that requests it, so port 1
    // cannot slip between the AMO load and its store.
    locked = (state_q == ST_LOCK0) || (resp && !owner_q && p0_lock);
    elig1  = cand1 && !locked;
    window = (state_q != ST_BUSY) || resp;
  end

  // Fixed priority to port 0, overridden once port 1 has waited too long.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (window) begin
      if (elig1 && (starve_q == LIMIT_C)) begin
        grant1 = 1'b1;
      end else if (cand0) begin
        grant0 = 1'b1;
      end else if (elig1) begin
        grant1 = 1'b1;
      end
    end
    issue = grant0 || grant1;
  end

  // Next state, request buffers and starvation counter.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    pend_v_d = pend_v_q;
    pend0_d  = pend0_q;
    pend1_d  = pend1_q;
    starve_d = starve_q;

    if (issue) begin
      state_d = ST_BUSY;
      owner_d = grant1;
    end else if (resp) begin
      state_d = (!owner_q && p0_lock) ? ST_LOCK0 : ST_IDLE;
    end

    if (grant0) begin
      pend_v_d[0] = 1'b0;
    end else if (acc0) begin
      pend_v_d[0] = 1'b1;
      pend0_d     = live0;
    end

    if (grant1) begin
      pend_v_d[1] = 1'b0;
    end else if (acc1) begin
      pend_v_d[1] = 1'b1;
      pend1_d     = live1;
    end

    if (grant1) begin
      starve_d = '0;
    end else if (grant0 && cand1 && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // State register with synchronous reset; buffered requests are dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      pend_v_q <= '0;
      pend0_q  <= '0;
      pend1_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      pend_v_q <= pend_v_d;
      pend0_q  <= pend0_d;
      pend1_q  <= pend1_d;
      starve_q <= starve_d;
    end
  end

  // Downstream request mux and upstream status.
  always_comb begin
    issue_req        = grant1 ? req1 : req0;
    lsu_prev_stalled = !issue;
    lsu_addr         = issue_req.addr;
    lsu_do_load      = issue && issue_req.ld;
    lsu_do_store     = issue && issue_req.st;
    lsu_store_data   = issue_req.data;
    lsu_store_mask   = issue_req.mask;

    p0_stall_next    = busy0 || acc0;
    p1_stall_next    = busy1 || acc1;
    p0_access_fault  = resp && !owner_q && lsu_access_fault;
    p1_access_fault  = resp &&  owner_q && lsu_access_fault;
    p0_load_data     = lsu_load_data;
    p1_load_data     = lsu_load_data;
  end

  // A requester must wait for stall_next to drop before raising a new request.
  a_p0_no_req_while_busy: assert property (@(posedge clk) disable iff (rst)
    !(busy0 && !p0_prev_stalled));
  a_p1_no_req_while_busy: assert property (@(posedge clk) disable iff (rst)
    !(busy1 && !p1_prev_stalled));

endmodule
